// File: rtl/psg_sound_gen.sv
// psg_sound_gen
// Sound-generation stage of an SN76489-compatible PSG. Three square-wave tone
// generators and one 16-bit LFSR noise generator run from a shared prescaler
// tick. Each channel is scaled by a logarithmic attenuation table, the four
// channels are summed into an 8-bit sample, and the sample drives a PWM pin.
//
// Ports
//   CLK       in   1   system clock, rising edge
//   RST       in   1   synchronous active-high reset
//   TONE0..2  in  10   tone half-periods in ticks (0 or 1 = constant high)
//   NOISE     in   3   [2] white(1)/periodic(0), [1:0] noise rate (3 = track tone 2)
//   NOISE_WR  in   1   one-cycle strobe, reseeds the LFSR to 0x8000
//   VOL0..3   in   4   attenuation for tone0/1/2 and noise (0 loudest, 15 off)
//   SAMPLE    out  8   registered mixed amplitude
//   AOUT      out  1   registered PWM output, duty = pwm_ref/256
//
// There is no FSM: the prescaler, channel counters, toggle bits, noise-edge
// history, LFSR and PWM counter make up all of the sequential state.

module psg_sound_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] TONE0,
  input  logic [9:0] TONE1,
  input  logic [9:0] TONE2,
  input  logic [2:0] NOISE,
  input  logic       NOISE_WR,
  input  logic [3:0] VOL0,
  input  logic [3:0] VOL1,
  input  logic [3:0] VOL2,
  input  logic [3:0] VOL3,
  output logic [7:0] SAMPLE,
  output logic       AOUT
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tone channels
  // ---------------------------------------------------------------------------
  logic [9:0] tone [3];
  logic [9:0] cnt  [3];
  logic [2:0] sq;

  assign tone[0] = TONE0;
  assign tone[1] = TONE1;
  assign tone[2] = TONE2;

  // A period of 0 or 1 pins the output high and parks the counter at 0, so a
  // later switch to a real period reloads and toggles on the very next tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      sq <= '0;
    end else if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (tone[i] <= 10'd1) begin
          cnt[i] <= '0;
          sq[i]  <= 1'b1;
        end else if (cnt[i] <= 10'd1) begin
          cnt[i] <= tone[i];
          sq[i]  <= ~sq[i];
        end else begin
          cnt[i] <= cnt[i] - 10'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Noise clock
  // ---------------------------------------------------------------------------
  logic [9:0] nreload;
  logic [9:0] ncnt;
  logic       nclk;
  logic       nsrc;
  logic       nsrc_q;
  logic       nshift;

  always_comb begin
    nreload = 10'd16;
    case (NOISE[1:0])
      2'd0:    nreload = 10'd16;
      2'd1:    nreload = 10'd32;
      2'd2:    nreload = 10'd64;
      default: nreload = 10'd0;
    endcase
  end

  // Rate 3 has no counter of its own; the internal clock is parked low so a
  // later switch back to a fixed rate restarts it on the next tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ncnt <= '0;
      nclk <= 1'b0;
    end else if (tick) begin
      if (NOISE[1:0] == 2'd3) begin
        ncnt <= '0;
        nclk <= 1'b0;
      end else if (ncnt <= 10'd1) begin
        ncnt <= nreload;
        nclk <= ~nclk;
      end else begin
        ncnt <= ncnt - 10'd1;
      end
    end
  end

  // The edge detector compares the currently selected source with its value
  // one cycle earlier, so a rate change alone only shifts on a real 0->1.
  assign nsrc   = (NOISE[1:0] == 2'd3) ? sq[2] : nclk;
  assign nshift = nsrc & ~nsrc_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      nsrc_q <= 1'b0;
    end else begin
      nsrc_q <= nsrc;
    end
  end

  // ---------------------------------------------------------------------------
  // LFSR (reseed has priority over a coincident shift)
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr;
  logic        fb;

  assign fb = NOISE[2] ? (lfsr[0] ^ lfsr[3]) : lfsr[0];

  always_ff @(posedge CLK) begin
    if (RST || NOISE_WR) begin
      lfsr <= 16'h8000;
    end else if (nshift) begin
      lfsr <= {fb, lfsr[15:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Attenuation and mixer
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] amp(input logic [3:0] v);
    logic [7:0] a;
    case (v)
      4'd0:    a = 8'd63;
      4'd1:    a = 8'd50;
      4'd2:    a = 8'd40;
      4'd3:    a = 8'd32;
      4'd4:    a = 8'd25;
      4'd5:    a = 8'd20;
      4'd6:    a = 8'd16;
      4'd7:    a = 8'd13;
      4'd8:    a = 8'd10;
      4'd9:    a = 8'd8;
      4'd10:   a = 8'd6;
      4'd11:   a = 8'd5;
      4'd12:   a = 8'd4;
      4'd13:   a = 8'd3;
      4'd14:   a = 8'd2;
      default: a = 8'd0;
    endcase
    return a;
  endfunction

  logic [7:0] mix;

  // Four channels of at most 63 sum to 252, so 8 bits never overflow.
  always_comb begin
    mix = (sq[0]   ? amp(VOL0) : 8'd0)
        + (sq[1]   ? amp(VOL1) : 8'd0)
        + (sq[2]   ? amp(VOL2) : 8'd0)
        + (lfsr[0] ? amp(VOL3) : 8'd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SAMPLE <= '0;
    end else begin
      SAMPLE <= mix;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM: reference is only refreshed at the counter wrap so each 256-cycle
  // frame has a constant duty.
  // ---------------------------------------------------------------------------
  logic [7:0] pc;
  logic [7:0] pwm_ref;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc      <= '0;
      pwm_ref <= '0;
      AOUT    <= 1'b0;
    end else begin
      pc   <= pc + 8'd1;
      AOUT <= (pc < pwm_ref);
      if (pc == 8'd255) begin
        pwm_ref <= SAMPLE;
      end
    end
  end

endmodule

// File: tb/tb_psg_sound_gen.sv
// tb_psg_sound_gen
// Bench for psg_sound_gen. A tick-scheduled model (absolute tick numbers of
// the next toggle per channel, integer LFSR, integer PWM counter) predicts
// SAMPLE, AOUT, the LFSR and the tone bits every cycle; directed phases add
// hand-computed literal expectations at specific edge counts after reset.

module tb_psg_sound_gen;

  localparam int CLK_DIV = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] TONE0 = '0;
  logic [9:0] TONE1 = '0;
  logic [9:0] TONE2 = '0;
  logic [2:0] NOISE = '0;
  logic       NOISE_WR = 1'b0;
  logic [3:0] VOL0 = 4'd15;
  logic [3:0] VOL1 = 4'd15;
  logic [3:0] VOL2 = 4'd15;
  logic [3:0] VOL3 = 4'd15;
  logic [7:0] SAMPLE;
  logic       AOUT;

  psg_sound_gen #(.CLK_DIV(CLK_DIV)) dut (
    .CLK(CLK), .RST(RST),
    .TONE0(TONE0), .TONE1(TONE1), .TONE2(TONE2),
    .NOISE(NOISE), .NOISE_WR(NOISE_WR),
    .VOL0(VOL0), .VOL1(VOL1), .VOL2(VOL2), .VOL3(VOL3),
    .SAMPLE(SAMPLE), .AOUT(AOUT)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Counters and check helper
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, evaluated at each rising edge from the inputs only
  // ---------------------------------------------------------------------------
  int          amp_tab [16] = '{63, 50, 40, 32, 25, 20, 16, 13, 10, 8, 6, 5, 4, 3, 2, 0};
  bit          model_valid = 1'b0;
  int          m_edges;
  int          nxt [3];
  int          n_nxt;
  logic [2:0]  m_sq;
  logic        m_nclk;
  logic        m_prev;
  logic [15:0] m_lfsr;
  logic [7:0]  m_sample;
  int          m_pc;
  int          m_ref;
  logic        m_aout;

  logic [2:0]  o_sq;
  logic        o_nclk;
  logic [15:0] o_lfsr;
  logic [7:0]  o_sample;
  int          o_pc;
  int          o_ref;
  logic        src;
  int          sum;
  int          k;
  int          t_in [3];

  always @(posedge CLK) begin
    if (RST) begin
      model_valid = 1'b1;
      m_edges  = 0;
      for (int i = 0; i < 3; i++) nxt[i] = 1;
      n_nxt    = 1;
      m_sq     = '0;
      m_nclk   = 1'b0;
      m_prev   = 1'b0;
      m_lfsr   = 16'h8000;
      m_sample = '0;
      m_pc     = 0;
      m_ref    = 0;
      m_aout   = 1'b0;
    end else if (model_valid) begin
      o_sq = m_sq; o_nclk = m_nclk; o_lfsr = m_lfsr;
      o_sample = m_sample; o_pc = m_pc; o_ref = m_ref;
      m_edges++;

      sum = 0;
      if (o_sq[0])   sum += amp_tab[VOL0];
      if (o_sq[1])   sum += amp_tab[VOL1];
      if (o_sq[2])   sum += amp_tab[VOL2];
      if (o_lfsr[0]) sum += amp_tab[VOL3];
      m_sample = sum[7:0];

      m_aout = (o_pc < o_ref);
      if (o_pc == 255) m_ref = o_sample;
      m_pc = (o_pc + 1) % 256;

      src = (NOISE[1:0] == 2'd3) ? o_sq[2] : o_nclk;
      if (NOISE_WR) m_lfsr = 16'h8000;
      else if (src && !m_prev)
        m_lfsr = {(NOISE[2] ? (o_lfsr[0] ^ o_lfsr[3]) : o_lfsr[0]), o_lfsr[15:1]};
      m_prev = src;

      if (m_edges % CLK_DIV == 0) begin
        k = m_edges / CLK_DIV;
        t_in[0] = int'(TONE0); t_in[1] = int'(TONE1); t_in[2] = int'(TONE2);
        for (int i = 0; i < 3; i++) begin
          if (t_in[i] <= 1) begin
            m_sq[i] = 1'b1;
            nxt[i]  = k + 1;
          end else if (k == nxt[i]) begin
            m_sq[i] = ~m_sq[i];
            nxt[i]  = k + t_in[i];
          end
        end
        if (NOISE[1:0] == 2'd3) begin
          m_nclk = 1'b0;
          n_nxt  = k + 1;
        end else if (k == n_nxt) begin
          m_nclk = ~m_nclk;
          n_nxt  = k + (16 << NOISE[1:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (model_valid) begin
      check("sample", SAMPLE, m_sample);
      check("aout", AOUT, m_aout);
      check("lfsr", dut.lfsr, m_lfsr);
      check("sq", dut.sq, m_sq);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic set_cfg(input int t0, input int t1, input int t2, input logic [2:0] nz,
                         input int v0, input int v1, input int v2, input int v3);
    TONE0 = 10'(t0); TONE1 = 10'(t1); TONE2 = 10'(t2);
    NOISE = nz;
    VOL0 = 4'(v0); VOL1 = 4'(v1); VOL2 = 4'(v2); VOL3 = 4'(v3);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_edge(input int n);
    int guard = 0;
    while (m_edges < n && guard < 20000) begin
      @(negedge CLK);
      guard++;
    end
    if (m_edges < n) begin
      total++;
      bad++;
      $display("FAIL wait_bound: reached edge %0d expected %0d", m_edges, n);
    end
  endtask

  task automatic pulse_wr();
    NOISE_WR = 1'b1;
    @(negedge CLK);
    NOISE_WR = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int hi;
  int nz_cnt;

  initial begin
    @(negedge CLK);
    RST = 1'b0;
    check("rst_sample", SAMPLE, 8'd0);
    check("rst_aout", AOUT, 1'b0);
    check("rst_lfsr", dut.lfsr, 16'h8000);
    check("rst_sq", dut.sq, 3'b000);

    // Tone square wave, TONE0 = 2
    set_cfg(2, 0, 0, 3'b000, 0, 15, 15, 15);
    do_reset();
    wait_edge(16); check("tone_k16", SAMPLE, 8'd0);
    wait_edge(17); check("tone_k17", SAMPLE, 8'd63);
    wait_edge(48); check("tone_k48", SAMPLE, 8'd63);
    wait_edge(49); check("tone_k49", SAMPLE, 8'd0);
    wait_edge(80); check("tone_k80", SAMPLE, 8'd0);
    wait_edge(81); check("tone_k81", SAMPLE, 8'd63);

    // Held-high tones at full volume
    set_cfg(0, 0, 0, 3'b000, 0, 0, 0, 15);
    do_reset();
    wait_edge(17); check("held_sample", SAMPLE, 8'd189);
    wait_edge(256);
    hi = 0;
    repeat (256) begin
      @(negedge CLK);
      if (AOUT) hi++;
    end
    check("held_duty", hi, 189);
    check("held_sample_late", SAMPLE, 8'd189);

    // Silence
    set_cfg(5, 7, 9, 3'b100, 15, 15, 15, 15);
    do_reset();
    nz_cnt = 0;
    repeat (600) begin
      @(negedge CLK);
      if (SAMPLE != 8'd0 || AOUT != 1'b0) nz_cnt++;
    end
    check("silence", nz_cnt, 0);

    // Periodic noise: shifts every 512 cycles from edge 529 after the reseed
    set_cfg(0, 0, 0, 3'b000, 15, 15, 15, 0);
    do_reset();
    wait_edge(20);
    pulse_wr();
    check("per_reseed", dut.lfsr, 16'h8000);
    wait_edge(7697);  check("per_k7697", SAMPLE, 8'd0);
    wait_edge(7698);  check("per_k7698", SAMPLE, 8'd63);
    wait_edge(8209);  check("per_k8209", SAMPLE, 8'd63);
    wait_edge(8210);  check("per_k8210", SAMPLE, 8'd0);
    wait_edge(15889); check("per_k15889", SAMPLE, 8'd0);
    wait_edge(15890); check("per_k15890", SAMPLE, 8'd63);

    // White noise: 19 and 20 shifts after reseed, then reseed on a shift edge
    set_cfg(0, 0, 0, 3'b100, 15, 15, 15, 15);
    do_reset();
    wait_edge(20);
    pulse_wr();
    wait_edge(10256); check("white_19", dut.lfsr, 16'h1200);
    wait_edge(10257); check("white_20", dut.lfsr, 16'h0900);
    wait_edge(10768);
    pulse_wr();
    check("white_reseed_wins", dut.lfsr, 16'h8000);

    // Reset mid-operation, landing on a tick edge
    set_cfg(0, 3, 5, 3'b011, 0, 15, 15, 15);
    do_reset();
    wait_edge(300);
    check("mid_sample_pre", SAMPLE, 8'd63);
    check("mid_aout_pre", AOUT, 1'b1);
    wait_edge(303);
    do_reset();
    check("mid_sample", SAMPLE, 8'd0);
    check("mid_aout", AOUT, 1'b0);
    check("mid_lfsr", dut.lfsr, 16'h8000);
    check("mid_sq", dut.sq, 3'b000);
    wait_edge(15); check("mid_sq0_k15", dut.sq[0], 1'b0);
    wait_edge(16); check("mid_sq0_k16", dut.sq[0], 1'b1);
    wait_edge(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
